// File: rtl/id_str_ctrl.sv
// id_str_ctrl: multi-channel identification-string reader on the AVR I/O bus.
// Software picks one of up to four constant strings via CTRL and streams it
// through DATA with auto-increment, optional wrap, peek and end-of-string flag.
module id_str_ctrl #(
    parameter logic [5:0] P_DATA_ADR  = 6'h13,
    parameter logic [5:0] P_CTRL_ADR  = 6'h14,
    parameter int         P_NUM_STR   = 2,
    parameter int         P_PTR_WIDTH = 7,
    localparam int        STR_W       = 8 * ((1 << P_PTR_WIDTH) - 1),
    parameter logic [STR_W-1:0] P_STR0 = STR_W'("ID0"),
    parameter logic [STR_W-1:0] P_STR1 = STR_W'("ID1"),
    parameter logic [STR_W-1:0] P_STR2 = STR_W'("ID2"),
    parameter logic [STR_W-1:0] P_STR3 = STR_W'("ID3"),
    parameter int         P_LEN0      = 3,
    parameter int         P_LEN1      = 3,
    parameter int         P_LEN2      = 3,
    parameter int         P_LEN3      = 3
) (
    input  logic       cp2,
    input  logic       ireset,
    input  logic [5:0] adr,
    input  logic [7:0] dbus_in,
    input  logic       iore,
    input  logic       iowe,
    output logic [7:0] dbus_out,
    output logic       out_en
);

    localparam int PW = P_PTR_WIDTH;

    // Length of string s in bytes.
    function automatic logic [PW-1:0] len_of(input logic [1:0] s);
        case (s)
            2'd0:    len_of = PW'(P_LEN0);
            2'd1:    len_of = PW'(P_LEN1);
            2'd2:    len_of = PW'(P_LEN2);
            default: len_of = PW'(P_LEN3);
        endcase
    endfunction

    // Byte i of string s (leftmost character is byte 0); 0x00 at/after the end.
    function automatic logic [7:0] chr(input logic [1:0] s, input logic [PW-1:0] i);
        logic [STR_W-1:0] str;
        logic [STR_W-1:0] shifted;
        logic [PW-1:0]    len;
        int               sh;
        case (s)
            2'd0:    str = P_STR0;
            2'd1:    str = P_STR1;
            2'd2:    str = P_STR2;
            default: str = P_STR3;
        endcase
        len = len_of(s);
        if (i >= len) begin
            chr = 8'h00;
        end else begin
            sh      = 8 * (int'(len) - 1 - int'(i));
            shifted = str >> sh;
            chr     = shifted[7:0];
        end
    endfunction

    logic [PW-1:0] ptr_q, ptr_d;
    logic [1:0]    sel_q, sel_d;
    logic          wrap_q, wrap_d;
    logic          peek_q, peek_d;
    logic [7:0]    data_rg_q, data_rg_d;

    logic          data_hit, ctrl_hit;
    logic          data_rd, data_wr, ctrl_wr;
    logic [PW-1:0] len_sel;
    logic          eos;
    logic [3:0]    ctrl_unused;

    assign data_hit    = (adr == P_DATA_ADR);
    assign ctrl_hit    = (adr == P_CTRL_ADR);
    // A read strobe at a matching address suppresses any simultaneous write.
    assign data_rd     = data_hit & iore;
    assign data_wr     = data_hit & iowe & ~iore;
    assign ctrl_wr     = ctrl_hit & iowe & ~iore;
    assign len_sel     = len_of(sel_q);
    assign eos         = (ptr_q == len_sel);
    assign out_en      = (data_hit | ctrl_hit) & iore;
    assign ctrl_unused = dbus_in[7:4];

    // Read mux: CTRL is a live combinational view, everything else the prefetch.
    always_comb begin
        dbus_out = data_rg_q;
        if (ctrl_hit) begin
            dbus_out = {eos, 3'b000, peek_q, wrap_q, sel_q};
        end
    end

    // Next-state: pointer advance/rewind, CTRL load, and prefetch from next state.
    always_comb begin
        ptr_d  = ptr_q;
        sel_d  = sel_q;
        wrap_d = wrap_q;
        peek_d = peek_q;
        if (data_rd) begin
            if (!peek_q) begin
                if (ptr_q < len_sel) begin
                    ptr_d = ptr_q + PW'(1);
                end else if (ptr_q == len_sel && wrap_q) begin
                    ptr_d = '0;
                end
            end
        end else if (data_wr) begin
            ptr_d = '0;
        end else if (ctrl_wr) begin
            sel_d  = (int'(dbus_in[1:0]) < P_NUM_STR) ? dbus_in[1:0] : 2'd0;
            wrap_d = dbus_in[2];
            peek_d = dbus_in[3];
            ptr_d  = '0;
        end
        // Prefetching from the next state lets back-to-back reads run without a bubble.
        data_rg_d = chr(sel_d, ptr_d);
    end

    // State registers with asynchronous reset.
    always_ff @(posedge cp2 or posedge ireset) begin
        if (ireset) begin
            ptr_q     <= '0;
            sel_q     <= 2'd0;
            wrap_q    <= 1'b0;
            peek_q    <= 1'b0;
            data_rg_q <= 8'h00;
        end else begin
            ptr_q     <= ptr_d;
            sel_q     <= sel_d;
            wrap_q    <= wrap_d;
            peek_q    <= peek_d;
            data_rg_q <= data_rg_d;
        end
    end

endmodule

// File: tb/tb_id_str_ctrl.sv
// Directed bench for id_str_ctrl with strings "AB" (sel 0) and "XYZ" (sel 1).
module tb_id_str_ctrl;

    localparam int         SW   = 8 * 127;
    localparam logic [5:0] DATA = 6'h13;
    localparam logic [5:0] CTRL = 6'h14;

    logic       cp2 = 1'b0;
    logic       ireset = 1'b1;
    logic [5:0] adr = 6'h00;
    logic [7:0] dbus_in = 8'h00;
    logic       iore = 1'b0;
    logic       iowe = 1'b0;
    logic [7:0] dbus_out;
    logic       out_en;

    int errors = 0;
    int checks = 0;

    id_str_ctrl #(
        .P_NUM_STR(2),
        .P_STR0(SW'("AB")),
        .P_LEN0(2),
        .P_STR1(SW'("XYZ")),
        .P_LEN1(3)
    ) dut (
        .cp2(cp2),
        .ireset(ireset),
        .adr(adr),
        .dbus_in(dbus_in),
        .iore(iore),
        .iowe(iowe),
        .dbus_out(dbus_out),
        .out_en(out_en)
    );

    always #5 cp2 = ~cp2;

    // One bus cycle: drive just after the rising edge, return at the falling edge.
    task automatic setbus(input logic [5:0] a, input logic re, input logic we, input logic [7:0] d);
        @(posedge cp2);
        #1;
        adr = a; iore = re; iowe = we; dbus_in = d;
        @(negedge cp2);
    endtask

    task automatic test_reset;
        logic [7:0] exp_b [4];
        exp_b = '{8'h41, 8'h42, 8'h00, 8'h00};
        repeat (2) @(posedge cp2);
        #1;
        checks++;
        if (dbus_out !== 8'h00) begin errors++; $display("FAIL rst_dbus got %h exp %h", dbus_out, 8'h00); end
        checks++;
        if (out_en !== 1'b0) begin errors++; $display("FAIL rst_out_en got %b exp %b", out_en, 1'b0); end
        @(posedge cp2);
        #1;
        ireset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            setbus(DATA, 1'b1, 1'b0, 8'h00);
            checks++;
            if (dbus_out !== exp_b[i]) begin errors++; $display("FAIL t1_rd%0d got %h exp %h", i, dbus_out, exp_b[i]); end
            checks++;
            if (out_en !== 1'b1) begin errors++; $display("FAIL t1_oen%0d got %b exp %b", i, out_en, 1'b1); end
        end
        setbus(CTRL, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h80) begin errors++; $display("FAIL t1_ctrl_eos got %h exp %h", dbus_out, 8'h80); end
        setbus(6'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_wrap;
        logic [7:0] exp_b [9];
        exp_b = '{8'h58, 8'h59, 8'h5A, 8'h00, 8'h58, 8'h59, 8'h5A, 8'h00, 8'h58};
        setbus(CTRL, 1'b0, 1'b1, 8'h05);
        for (int i = 0; i < 9; i++) begin
            setbus(DATA, 1'b1, 1'b0, 8'h00);
            checks++;
            if (dbus_out !== exp_b[i]) begin errors++; $display("FAIL t2_rd%0d got %h exp %h", i, dbus_out, exp_b[i]); end
        end
        setbus(6'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_peek;
        setbus(CTRL, 1'b0, 1'b1, 8'h08);
        for (int i = 0; i < 3; i++) begin
            setbus(DATA, 1'b1, 1'b0, 8'h00);
            checks++;
            if (dbus_out !== 8'h41) begin errors++; $display("FAIL t3_peek%0d got %h exp %h", i, dbus_out, 8'h41); end
        end
        setbus(CTRL, 1'b0, 1'b1, 8'h00);
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h41) begin errors++; $display("FAIL t3_rd0 got %h exp %h", dbus_out, 8'h41); end
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h42) begin errors++; $display("FAIL t3_rd1 got %h exp %h", dbus_out, 8'h42); end
        setbus(6'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_rewind_and_sel_range;
        setbus(CTRL, 1'b0, 1'b1, 8'h01);
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h58) begin errors++; $display("FAIL t4_rdX got %h exp %h", dbus_out, 8'h58); end
        setbus(DATA, 1'b0, 1'b1, 8'hFF);
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h58) begin errors++; $display("FAIL t4_rewind got %h exp %h", dbus_out, 8'h58); end
        setbus(CTRL, 1'b0, 1'b1, 8'h03);
        setbus(CTRL, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h00) begin errors++; $display("FAIL t4_ctrl_sel got %h exp %h", dbus_out, 8'h00); end
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h41) begin errors++; $display("FAIL t4_sel0_rd got %h exp %h", dbus_out, 8'h41); end
        setbus(6'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_midstream;
        setbus(CTRL, 1'b0, 1'b1, 8'h05);
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h59) begin errors++; $display("FAIL t5_preY got %h exp %h", dbus_out, 8'h59); end
        #1;
        ireset = 1'b1;
        #1;
        checks++;
        if (dbus_out !== 8'h00) begin errors++; $display("FAIL t5_rst_data got %h exp %h", dbus_out, 8'h00); end
        adr = CTRL;
        #1;
        checks++;
        if (dbus_out !== 8'h00) begin errors++; $display("FAIL t5_rst_ctrl got %h exp %h", dbus_out, 8'h00); end
        iore = 1'b0;
        @(posedge cp2);
        #1;
        ireset = 1'b0;
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h41) begin errors++; $display("FAIL t5_after_rst got %h exp %h", dbus_out, 8'h41); end
        setbus(6'h00, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_bus_decode;
        setbus(CTRL, 1'b0, 1'b1, 8'h05);
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        setbus(6'h15, 1'b1, 1'b0, 8'h00);
        checks++;
        if (out_en !== 1'b0) begin errors++; $display("FAIL t6_oen_rd got %b exp %b", out_en, 1'b0); end
        setbus(6'h15, 1'b0, 1'b1, 8'h0A);
        checks++;
        if (out_en !== 1'b0) begin errors++; $display("FAIL t6_oen_wr got %b exp %b", out_en, 1'b0); end
        setbus(6'h15, 1'b1, 1'b1, 8'h0A);
        setbus(CTRL, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h05) begin errors++; $display("FAIL t6_ctrl_keep got %h exp %h", dbus_out, 8'h05); end
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h59) begin errors++; $display("FAIL t6_ptr_keep got %h exp %h", dbus_out, 8'h59); end
        setbus(DATA, 1'b1, 1'b1, 8'h00);
        checks++;
        if (dbus_out !== 8'h5A) begin errors++; $display("FAIL t6_rdwr got %h exp %h", dbus_out, 8'h5A); end
        setbus(DATA, 1'b1, 1'b0, 8'h00);
        checks++;
        if (dbus_out !== 8'h00) begin errors++; $display("FAIL t6_no_clear got %h exp %h", dbus_out, 8'h00); end
        setbus(6'h00, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        test_reset;
        test_wrap;
        test_peek;
        test_rewind_and_sel_range;
        test_reset_midstream;
        test_bus_decode;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_str_ctrl.md
# id_str_ctrl

Multi-channel identification-string reader on the AVR I/O bus, successor to the single-string ID block. It holds up to four constant ASCII strings, such as core version, build tag and vendor. Software selects one through a control register and streams it byte by byte through a data register, with auto-increment, optional wrap-around, a non-advancing peek mode and an end-of-string flag. It sits alongside the other I/O peripherals on the `adr`/`iore`/`iowe` bus and drives the shared read mux through `out_en`.

## Interface
Parameters:
- `P_DATA_ADR`, 6'h13, I/O address of the DATA register.
- `P_CTRL_ADR`, 6'h14, I/O address of the CTRL register. Must differ from `P_DATA_ADR`.
- `P_NUM_STR`, 2, number of implemented strings, 1..4.
- `P_STR0`..`P_STR3`, "ID0".."ID3", packed string constants, MSB-first: byte 0 is the leftmost character.
- `P_LEN0`..`P_LEN3`, 3, length of each string in bytes. Each must be ≥1 and ≤ 2^`P_PTR_WIDTH`−1.
- `P_PTR_WIDTH`, 7, width of the pointer counter.

Ports (one clock; reset is asynchronous and active-high):
- `cp2`  in  1  clock; all state updates on the rising edge.
- `ireset`  in  1  asynchronous, active-high reset.
- `adr`  in  6  I/O address.
- `dbus_in`  in  8  write data.
- `iore`  in  1  I/O read strobe.
- `iowe`  in  1  I/O write strobe.
- `dbus_out`  out  8  read data.
- `out_en`  out  1  read-mux enable, equal to (`adr`==`P_DATA_ADR` or `adr`==`P_CTRL_ADR`) & `iore`.

## Operation
State:
- `ptr` (`P_PTR_WIDTH` bits).
- `sel` (2 bits).
- `wrap` (1 bit).
- `peek` (1 bit).
- `data_rg` (8 bits, prefetch register).

Character function: `chr(s,i)` = byte i of `P_STRs`, i.e. bits [8*(LEN_s−1−i) +: 8]. When i==LEN_s the result is 0x00, the terminator.

Prefetch:
- Every clock, `data_rg` <= `chr(sel_next, ptr_next)`.
- Therefore `data_rg` always holds the character at the current pointer.

DATA read (`adr`==DATA, `iore`):
- `dbus_out` = `data_rg`.
- If `peek`=1: `ptr` holds.
- Else if `ptr`<LEN_sel: `ptr`+1.
- Else if `ptr`==LEN_sel and `wrap`=1: `ptr` goes to 0.
- Else: `ptr` holds. The read returns 0x00 and saturates there.

DATA write (`adr`==DATA, `iowe`): `ptr` goes to 0. The `dbus_in` value is ignored.

CTRL write:
- `dbus_in[1:0]` loads `sel`. A value ≥ `P_NUM_STR` loads 0.
- `dbus_in[2]` loads `wrap`.
- `dbus_in[3]` loads `peek`.
- `ptr` goes to 0 on every CTRL write.
- Bits [7:4] are ignored.

CTRL read:
- `dbus_out` = {`eos`, 3'b000, `peek`, `wrap`, `sel`}, combinational.
- `eos` = (`ptr`==LEN_sel).
- A CTRL read has no side effect.

Other behaviour:
- `dbus_out` for any other address: `data_rg` (don't-care, because `out_en`=0).
- Simultaneous `iore` & `iowe` at a matching address: the read wins; the write is dropped.
- Unmatched addresses: no state change.

## Timing
Reset values, forced immediately on `ireset`=1 and held while asserted:
- `ptr`=0, `sel`=0, `wrap`=0, `peek`=0.
- `data_rg`=0x00.
- `out_en`=0 when the strobes are low.
- `dbus_out`=0x00.

After reset:
- `data_rg` becomes `chr(0,0)` on the first `cp2` rising edge after `ireset` deasserts.
- A DATA read in the first cycle after reset returns 0x00.

Read and write timing:
- Read data is valid in the same cycle as `iore`, because `dbus_out` comes from registers or the combinational CTRL view.
- The pointer side effect lands on the following rising edge.
- Back-to-back DATA reads on consecutive cycles return consecutive characters with no bubble, because the prefetch uses `ptr_next`.
- A write to DATA or CTRL takes effect on its rising edge. A read in the next cycle returns `chr(sel_new, 0)`.

Reset mid-stream: the next read after release, excluding the first cycle, returns `chr(0,0)`.

## Test plan
Setup for all cases: `P_NUM_STR`=2, `P_STR0`="AB" with `P_LEN0`=2, `P_STR1`="XYZ" with `P_LEN1`=3.

1. Reset, one idle cycle, then 4 consecutive DATA reads → 0x41, 0x42, 0x00, 0x00. `out_en`=1 on each read cycle. A CTRL read then returns 0x80 (`eos`=1).
2. CTRL write 0x05 (`sel`=1, `wrap`=1), then 9 consecutive DATA reads → X, Y, Z, 00, X, Y, Z, 00, X (0x58 0x59 0x5A 0x00 0x58…).
3. CTRL write 0x08 (`peek`, `sel`=0), 3 DATA reads → 0x41 ×3. CTRL write 0x00, 1 DATA read → 0x41, then the next read → 0x42.
4. Mid-string (after reading "X"), DATA write 0xFF → the next read returns 0x58. CTRL write 0x03 (`sel` out of range) → CTRL read 0x00 and DATA read 0x41.
5. Assert `ireset` for 1 cycle mid-stream of string 1 with `wrap`=1 → `dbus_out`=0x00 immediately. CTRL reads 0x00. After one clock, DATA read → 0x41.
6. `adr`=6'h15 with `iore`/`iowe` pulses → `out_en`=0 and no change in the `ptr`/`sel` readback. DATA address with `iore`=`iowe`=1 → `ptr` increments; no clear occurs.
